gpr_file: RTL and testbench

//   Architectural general-purpose register file; receiving end of the execute-stage write-back (srd/gpr_w_en).

---
 rtl/gpr_file_pkg.sv | 26 ++
 rtl/gpr_file_if.sv | 59 +++++
 rtl/gpr_file_read_port.sv | 45 ++++
 rtl/gpr_file.sv | 104 ++++++++++
 tb/tb_gpr_file.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpr_file_pkg.sv
// Shared GPR file configuration and helper types.
// Widths here are shared with decode and exu.
package gpr_file_pkg;

  localparam int ISA_WIDTH      = 32;
  localparam int GPR_ADDR_WIDTH = 5;
  localparam int GPR_NUM        = 32;
  localparam int RETIRE_W       = 64;

  typedef logic [RETIRE_W-1:0] retire_t;

  typedef enum logic [1:0] {
    WR_IDLE  = 2'b00,
    WR_HOLD  = 2'b01,
    WR_RETIRE = 2'b10,
    WR_COMMIT = 2'b11
  } wr_kind_e;

  function automatic wr_kind_e wr_kind(
    input logic wb_valid,
    input logic gpr_w_en
  );
    return wr_kind_e'({wb_valid, gpr_w_en});
  endfunction

endpackage

// File: rtl/gpr_file_if.sv
// GPR file bus: decode/exu side is master,
// register file is slave.
interface gpr_file_if
  import gpr_file_pkg::*;
#(
  parameter int XLEN   = ISA_WIDTH,
  parameter int ADDR_W = GPR_ADDR_WIDTH
);

  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic [XLEN-1:0]   src1;
  logic [XLEN-1:0]   src2;
  logic [ADDR_W-1:0] rd_addr;
  logic [XLEN-1:0]   srd;
  logic              gpr_w_en;
  logic              wb_valid;
  logic [ADDR_W-1:0] dbg_addr;
  logic [XLEN-1:0]   dbg_data;
  logic [ADDR_W-1:0] last_wr_addr;
  logic [XLEN-1:0]   last_wr_data;
  logic              last_wr_vld;
  retire_t           retire_cnt;

  modport master (
    output rs1_addr,
    output rs2_addr,
    input  src1,
    input  src2,
    output rd_addr,
    output srd,
    output gpr_w_en,
    output wb_valid,
    output dbg_addr,
    input  dbg_data,
    input  last_wr_addr,
    input  last_wr_data,
    input  last_wr_vld,
    input  retire_cnt
  );

  modport slave (
    input  rs1_addr,
    input  rs2_addr,
    output src1,
    output src2,
    input  rd_addr,
    input  srd,
    input  gpr_w_en,
    input  wb_valid,
    input  dbg_addr,
    output dbg_data,
    output last_wr_addr,
    output last_wr_data,
    output last_wr_vld,
    output retire_cnt
  );

endinterface

// File: rtl/gpr_file_read_port.sv
// One combinational read port: index select,
// x0/out-of-range mask, optional write bypass.
module gpr_read_port #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5,
  parameter int NR_REG = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   regs [NR_REG],
  input  logic              byp_en,
  input  logic [ADDR_W-1:0] byp_addr,
  input  logic [XLEN-1:0]   byp_data,
  output logic [XLEN-1:0]   data
);

  logic [XLEN-1:0] sel;
  logic            in_rng;
  logic            hit;

  // loop compare keeps the narrow RV32E array
  // safe from wide indices
  always_comb begin
    sel    = '0;
    in_rng = 1'b0;
    for (int i = 0; i < NR_REG; i++) begin
      if (addr == ADDR_W'(i)) begin
        sel    = regs[i];
        in_rng = 1'b1;
      end
    end
  end

  assign hit = BYPASS && byp_en &&
               (byp_addr == addr);

  always_comb begin
    data = sel;
    if (addr == '0 || !in_rng)
      data = '0;
    else if (hit)
      data = byp_data;
  end

endmodule

// File: rtl/gpr_file.sv
// Architectural GPR file with commit-gated write,
// same-cycle bypass, difftest port and retire trace.
module gpr_file
  import gpr_file_pkg::*;
#(
  parameter int XLEN   = ISA_WIDTH,
  parameter int ADDR_W = GPR_ADDR_WIDTH,
  parameter int NR_REG = GPR_NUM
) (
  input  logic     clk,
  input  logic     rst,
  gpr_file_if.slave bus
);

  logic [XLEN-1:0] regs [NR_REG];
  logic            rd_ok;
  logic            wr_req;
  logic            commit;
  wr_kind_e        kind;

  assign kind   = wr_kind(bus.wb_valid, bus.gpr_w_en);
  assign wr_req = (kind == WR_COMMIT);

  always_comb begin
    rd_ok = 1'b0;
    for (int i = 1; i < NR_REG; i++) begin
      if (bus.rd_addr == ADDR_W'(i))
        rd_ok = 1'b1;
    end
  end

  assign commit = wr_req && rd_ok;

  // regs[0] is only ever cleared, so x0 stays 0
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR_REG; i++)
        regs[i] <= '0;
    end else if (commit) begin
      for (int i = 1; i < NR_REG; i++) begin
        if (bus.rd_addr == ADDR_W'(i))
          regs[i] <= bus.srd;
      end
    end
  end

  gpr_read_port #(
    .XLEN(XLEN), .ADDR_W(ADDR_W),
    .NR_REG(NR_REG), .BYPASS(1'b1)
  ) u_rp1 (
    .addr     (bus.rs1_addr),
    .regs     (regs),
    .byp_en   (wr_req),
    .byp_addr (bus.rd_addr),
    .byp_data (bus.srd),
    .data     (bus.src1)
  );

  gpr_read_port #(
    .XLEN(XLEN), .ADDR_W(ADDR_W),
    .NR_REG(NR_REG), .BYPASS(1'b1)
  ) u_rp2 (
    .addr     (bus.rs2_addr),
    .regs     (regs),
    .byp_en   (wr_req),
    .byp_addr (bus.rd_addr),
    .byp_data (bus.srd),
    .data     (bus.src2)
  );

  gpr_read_port #(
    .XLEN(XLEN), .ADDR_W(ADDR_W),
    .NR_REG(NR_REG), .BYPASS(1'b0)
  ) u_rpd (
    .addr     (bus.dbg_addr),
    .regs     (regs),
    .byp_en   (1'b0),
    .byp_addr ('0),
    .byp_data ('0),
    .data     (bus.dbg_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.last_wr_addr <= '0;
      bus.last_wr_data <= '0;
      bus.last_wr_vld  <= 1'b0;
    end else begin
      bus.last_wr_vld <= commit;
      if (commit) begin
        bus.last_wr_addr <= bus.rd_addr;
        bus.last_wr_data <= bus.srd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      bus.retire_cnt <= '0;
    else if (bus.wb_valid)
      bus.retire_cnt <= bus.retire_cnt + 1'b1;
  end

endmodule

// File: tb/tb_gpr_file.sv
// Directed bench for gpr_file: full-width (32 regs)
// and RV32E (16 regs) instances.
module tb_gpr_file;
  import gpr_file_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  gpr_file_if #(.XLEN(32), .ADDR_W(5)) b ();
  gpr_file_if #(.XLEN(32), .ADDR_W(5)) e ();

  gpr_file #(.XLEN(32), .ADDR_W(5), .NR_REG(32)) dut (
    .clk (clk), .rst (rst), .bus (b)
  );

  gpr_file #(.XLEN(32), .ADDR_W(5), .NR_REG(16)) dut16 (
    .clk (clk), .rst (rst), .bus (e)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    b.rs1_addr = '0; b.rs2_addr = '0;
    b.rd_addr  = '0; b.srd      = '0;
    b.gpr_w_en = 1'b0; b.wb_valid = 1'b0;
    b.dbg_addr = '0;
    e.rs1_addr = '0; e.rs2_addr = '0;
    e.rd_addr  = '0; e.srd      = '0;
    e.gpr_w_en = 1'b0; e.wb_valid = 1'b0;
    e.dbg_addr = '0;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [31:0] d);
    b.rd_addr = rd; b.srd = d;
    b.gpr_w_en = 1'b1; b.wb_valid = 1'b1;
  endtask

  task automatic no_commit();
    b.gpr_w_en = 1'b0; b.wb_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_all();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      b.rs1_addr = 5'(i); b.rs2_addr = 5'(i); b.dbg_addr = 5'(i);
      #1;
      checks++;
      if (b.src1 !== 32'h0 || b.src2 !== 32'h0 || b.dbg_data !== 32'h0) begin
        errors++;
        $display("FAIL reset_read idx=%0d src1=%h src2=%h dbg=%h want 0",
                 i, b.src1, b.src2, b.dbg_data);
      end
    end
    checks++;
    if (b.retire_cnt !== 64'd0) begin
      errors++;
      $display("FAIL reset_retire got %0d want 0", b.retire_cnt);
    end
    checks++;
    if (b.last_wr_vld !== 1'b0 || b.last_wr_addr !== 5'd0 || b.last_wr_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_trace vld=%b addr=%0d data=%h want 0/0/0",
               b.last_wr_vld, b.last_wr_addr, b.last_wr_data);
    end
  endtask

  task automatic test_write();
    commit(5'd5, 32'hDEADBEEF);
    tick();
    no_commit();
    b.dbg_addr = 5'd5;
    #1;
    checks++;
    if (b.dbg_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_dbg got %h want deadbeef", b.dbg_data);
    end
    checks++;
    if (b.last_wr_vld !== 1'b1 || b.last_wr_addr !== 5'd5 || b.last_wr_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_trace vld=%b addr=%0d data=%h want 1/5/deadbeef",
               b.last_wr_vld, b.last_wr_addr, b.last_wr_data);
    end
    checks++;
    if (b.retire_cnt !== 64'd1) begin
      errors++;
      $display("FAIL write_retire got %0d want 1", b.retire_cnt);
    end
    tick();
    checks++;
    if (b.last_wr_vld !== 1'b0 || b.last_wr_addr !== 5'd5) begin
      errors++;
      $display("FAIL write_pulse vld=%b addr=%0d want 0/5",
               b.last_wr_vld, b.last_wr_addr);
    end
  endtask

  task automatic test_x0();
    commit(5'd0, 32'h1234);
    b.rs1_addr = 5'd0;
    #1;
    checks++;
    if (b.src1 !== 32'h0) begin
      errors++;
      $display("FAIL x0_bypass got %h want 0", b.src1);
    end
    tick();
    no_commit();
    b.dbg_addr = 5'd0;
    #1;
    checks++;
    if (b.dbg_data !== 32'h0) begin
      errors++;
      $display("FAIL x0_dbg got %h want 0", b.dbg_data);
    end
    checks++;
    if (b.retire_cnt !== 64'd2 || b.last_wr_vld !== 1'b0) begin
      errors++;
      $display("FAIL x0_retire cnt=%0d vld=%b want 2/0",
               b.retire_cnt, b.last_wr_vld);
    end
  endtask

  task automatic test_bypass();
    commit(5'd7, 32'h1111);
    tick();
    commit(5'd7, 32'hA5A5);
    b.rs1_addr = 5'd7; b.rs2_addr = 5'd7; b.dbg_addr = 5'd7;
    #1;
    checks++;
    if (b.src1 !== 32'hA5A5 || b.src2 !== 32'hA5A5) begin
      errors++;
      $display("FAIL bypass_src src1=%h src2=%h want a5a5",
               b.src1, b.src2);
    end
    checks++;
    if (b.dbg_data !== 32'h1111) begin
      errors++;
      $display("FAIL bypass_dbg_old got %h want 1111", b.dbg_data);
    end
    tick();
    no_commit();
    #1;
    checks++;
    if (b.dbg_data !== 32'hA5A5 || b.retire_cnt !== 64'd4) begin
      errors++;
      $display("FAIL bypass_dbg_new dbg=%h cnt=%0d want a5a5/4",
               b.dbg_data, b.retire_cnt);
    end
  endtask

  task automatic test_gated();
    commit(5'd9, 32'h99);
    tick();
    b.rd_addr = 5'd9; b.srd = 32'hBAD;
    b.gpr_w_en = 1'b1; b.wb_valid = 1'b0;
    b.rs1_addr = 5'd9; b.dbg_addr = 5'd9;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (b.src1 !== 32'h99) begin
        errors++;
        $display("FAIL gated_src cyc=%0d got %h want 99", c, b.src1);
      end
      tick();
    end
    no_commit();
    #1;
    checks++;
    if (b.dbg_data !== 32'h99 || b.retire_cnt !== 64'd5) begin
      errors++;
      $display("FAIL gated_state dbg=%h cnt=%0d want 99/5",
               b.dbg_data, b.retire_cnt);
    end
  endtask

  task automatic test_retire_only();
    b.wb_valid = 1'b1; b.gpr_w_en = 1'b0;
    b.rd_addr = 5'd9; b.srd = 32'hF00D;
    repeat (3) tick();
    no_commit();
    #1;
    checks++;
    if (b.retire_cnt !== 64'd8 || b.last_wr_vld !== 1'b0 || b.dbg_data !== 32'h99) begin
      errors++;
      $display("FAIL retire_only cnt=%0d vld=%b dbg=%h want 8/0/99",
               b.retire_cnt, b.last_wr_vld, b.dbg_data);
    end
  endtask

  task automatic test_back_to_back();
    commit(5'd10, 32'hA0);
    tick();
    commit(5'd11, 32'hB0);
    b.rs1_addr = 5'd10;
    #1;
    checks++;
    if (b.src1 !== 32'hA0 || b.last_wr_addr !== 5'd10 || b.last_wr_vld !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first src1=%h addr=%0d vld=%b want a0/10/1",
               b.src1, b.last_wr_addr, b.last_wr_vld);
    end
    tick();
    commit(5'd12, 32'hC0);
    b.rs1_addr = 5'd11; b.rs2_addr = 5'd12;
    #1;
    checks++;
    if (b.src1 !== 32'hB0 || b.src2 !== 32'hC0 || b.last_wr_addr !== 5'd11) begin
      errors++;
      $display("FAIL b2b_second src1=%h src2=%h addr=%0d want b0/c0/11",
               b.src1, b.src2, b.last_wr_addr);
    end
    tick();
    no_commit();
    b.dbg_addr = 5'd12;
    #1;
    checks++;
    if (b.dbg_data !== 32'hC0 || b.last_wr_data !== 32'hC0 || b.retire_cnt !== 64'd11) begin
      errors++;
      $display("FAIL b2b_final dbg=%h data=%h cnt=%0d want c0/c0/11",
               b.dbg_data, b.last_wr_data, b.retire_cnt);
    end
  endtask

  task automatic test_reset_vs_commit();
    rst = 1'b1;
    commit(5'd3, 32'h55);
    tick();
    rst = 1'b0;
    no_commit();
    b.dbg_addr = 5'd3;
    #1;
    checks++;
    if (b.dbg_data !== 32'h0 || b.retire_cnt !== 64'd0 || b.last_wr_vld !== 1'b0) begin
      errors++;
      $display("FAIL rst_commit dbg=%h cnt=%0d vld=%b want 0/0/0",
               b.dbg_data, b.retire_cnt, b.last_wr_vld);
    end
    b.dbg_addr = 5'd5;
    #1;
    checks++;
    if (b.dbg_data !== 32'h0) begin
      errors++;
      $display("FAIL rst_clears got %h want 0", b.dbg_data);
    end
  endtask

  task automatic test_rv32e();
    e.rd_addr = 5'd20; e.srd = 32'h77;
    e.gpr_w_en = 1'b1; e.wb_valid = 1'b1;
    e.rs1_addr = 5'd20;
    #1;
    checks++;
    if (e.src1 !== 32'h0) begin
      errors++;
      $display("FAIL e_range_read got %h want 0", e.src1);
    end
    tick();
    e.rd_addr = 5'd15; e.srd = 32'hF15;
    #1;
    checks++;
    if (e.last_wr_vld !== 1'b0) begin
      errors++;
      $display("FAIL e_range_trace vld=%b want 0", e.last_wr_vld);
    end
    tick();
    e.gpr_w_en = 1'b0; e.wb_valid = 1'b0;
    e.dbg_addr = 5'd4;
    #1;
    checks++;
    if (e.dbg_data !== 32'h0) begin
      errors++;
      $display("FAIL e_alias got %h want 0", e.dbg_data);
    end
    e.dbg_addr = 5'd20;
    #1;
    checks++;
    if (e.dbg_data !== 32'h0) begin
      errors++;
      $display("FAIL e_range_dbg got %h want 0", e.dbg_data);
    end
    e.dbg_addr = 5'd15;
    #1;
    checks++;
    if (e.dbg_data !== 32'hF15 || e.retire_cnt !== 64'd2 || e.last_wr_addr !== 5'd15) begin
      errors++;
      $display("FAIL e_top_reg dbg=%h cnt=%0d addr=%0d want f15/2/15",
               e.dbg_data, e.retire_cnt, e.last_wr_addr);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    test_reset();
    test_write();
    test_x0();
    test_bypass();
    test_gated();
    test_retire_only();
    test_back_to_back();
    test_reset_vs_commit();
    test_rv32e();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
